sad_window_gen: RTL and testbench
=================================

# sad_window_gen

Streaming window generator that feeds the SAD disparity datapath. Accepts one image's pixels in raster order over a valid/ready stream. Buffers WIN-1 lines internally and emits every fully in-image WIN×WIN neighbourhood as one flat word in the element order the SAD stage consumes. One instance sits in front of each image (left/right) of the stereo pair.

## Interface
- WIN, 3: window side, odd, ≥3
- PIX_W, 8: bits per pixel
- IMG_W, 64: pixels per line, >WIN
- IMG_H, 64: lines per frame, ≥WIN
- WIN_SIZE, WIN*WIN: derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_pixel  in  PIX_W  input pixel, raster order, row 0 col 0 first
- m_valid  out  1  window valid
- m_ready  in  1  window consumed when m_valid && m_ready
- m_window  out  WIN_SIZE*PIX_W  element k = r*WIN+c at bits [k*PIX_W +: PIX_W]; r=0 top (oldest) row, c=0 leftmost
- m_last  out  1  qualifies the final window of a frame

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance on every accepted pixel. col wraps to 0 and increments row. row wraps to 0 after the last pixel of a frame, so frames stream back to back with no gap.
- WIN-1 line buffers, each IMG_W deep, hold the previous WIN-1 lines. A WIN×WIN shift array is fed each accept with the current pixel plus the same column from each line buffer.
- Window condition: an accepted pixel at (row, col) with row ≥ WIN-1 and col ≥ WIN-1 completes a window whose bottom-right element is that pixel. No border padding.
- Windows per frame: (IMG_W-WIN+1)*(IMG_H-WIN+1).
- Output register is one deep. s_ready = !m_valid || m_ready. The stage stalls entirely under backpressure; no pixel is ever dropped.
- m_window and m_last hold stable while m_valid && !m_ready.
- m_last = 1 with the window completed by the pixel at (IMG_H-1, IMG_W-1).
- Line buffer contents are not cleared by reset. Validity is gated solely by the counters, so stale contents never appear in an emitted window.

## Timing
- Reset values: s_ready=1, m_valid=0, m_last=0, m_window=0, col=0, row=0.
- Latency: 1 cycle. A window is visible on m_valid the cycle after the completing pixel is accepted.
- Throughput: 1 pixel and at most 1 window per cycle.
- Simultaneous consume and accept in one cycle: the held window retires and the new window loads. m_valid stays 1 if the new pixel completes a window, otherwise it falls to 0.
- Accepted pixels that complete no window (rows <WIN-1, cols <WIN-1): m_valid goes to 0 on the next cycle if the held window was consumed.
- Reset asserted mid-frame: all outputs go to reset values immediately. The next accepted pixel is treated as (0,0).

## Configuration
- SAD_WINGEN_COORD_EN defined: adds the following output ports, both updated with m_window and held under stall. Their reset value is 0.
  - m_col, width $clog2(IMG_W): window-centre column = col-(WIN-1)/2.
  - m_row, width $clog2(IMG_H): window-centre row = row-(WIN-1)/2.
- SAD_WINGEN_COORD_EN undefined: these ports and their registers do not exist. Downstream logic derives position by counting windows.

## Test plan
All scenarios use WIN=3, PIX_W=8, IMG_W=8, IMG_H=4. Pixel value = row*8+col.
- Streaming, m_ready=1, s_valid=1 continuously:
  - First m_valid occurs 1 cycle after the 19th accept.
  - First m_window = {0,1,2,8,9,10,16,17,18}, element 0 first.
  - Exactly 12 windows per frame.
  - Last window = {13,14,15,21,22,23,29,30,31} with m_last=1.
- m_ready held 0 for 5 cycles while the first window is pending:
  - s_ready=0 throughout.
  - m_window is unchanged throughout.
  - After release, the sequence is identical to the first scenario, with no loss or duplication.
- Random s_valid and m_ready (50% each) over 3 back-to-back frames:
  - 36 windows total, all contents match a reference model.
  - m_last appears exactly 3 times.
- rst_n pulsed low after 13 pixels of frame 0:
  - m_valid=0 immediately.
  - A fresh frame then yields the first-scenario results exactly.
- With SAD_WINGEN_COORD_EN: the first window reports m_col=1, m_row=1, and the last window reports m_col=6, m_row=2.

Source files
------------

// File: rtl/sad_window_gen.sv
// Streaming WIN x WIN window generator for the SAD disparity datapath.
// Optional SAD_WINGEN_COORD_EN adds window-centre coordinate outputs m_col/m_row.
module sad_window_gen #(
    parameter int WIN   = 3,
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int WIN_SIZE = WIN * WIN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [PIX_W-1:0]          s_pixel,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIN_SIZE*PIX_W-1:0] m_window,
    output logic                      m_last
`ifdef SAD_WINGEN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0]  m_col,
    output logic [$clog2(IMG_H)-1:0]  m_row
`endif
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HALF = (WIN - 1) / 2;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(WIN - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          win_done;
    logic          frame_last;

    // line_buf[0] holds the previous line, line_buf[WIN-2] the oldest one.
    logic [PIX_W-1:0] line_buf [WIN-1][IMG_W];
    logic [PIX_W-1:0] win_q    [WIN][WIN];
    logic [PIX_W-1:0] win_d    [WIN][WIN];
    logic [PIX_W-1:0] tap      [WIN];
    logic [WIN_SIZE*PIX_W-1:0] win_flat;

    assign s_ready    = !m_valid || m_ready;
    assign accept     = s_valid && s_ready;
    assign win_done   = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);

    // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        win_flat     = '0;
        tap[WIN-1]   = s_pixel;
        for (int r = 0; r < WIN - 1; r++) begin
            tap[r] = line_buf[WIN-2-r][col];
        end
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN-1] = tap[r];
        end
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_flat[(r*WIN+c)*PIX_W +: PIX_W] = win_d[r][c];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // NOTE: line buffers and the shift array are not reset; the counters alone decide when their contents are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[0][col] <= s_pixel;
            for (int i = 1; i < WIN - 1; i++) begin
                line_buf[i][col] <= line_buf[i-1][col];
            end
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // One-deep output register; payload only changes when a new window loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_window <= '0;
            m_last   <= 1'b0;
`ifdef SAD_WINGEN_COORD_EN
            m_col    <= '0;
            m_row    <= '0;
`endif
        end else if (accept) begin
            m_valid <= win_done;
            if (win_done) begin
                m_window <= win_flat;
                m_last   <= frame_last;
`ifdef SAD_WINGEN_COORD_EN
                m_col    <= col - CW'(HALF);
                m_row    <= row - RW'(HALF);
`endif
            end
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sad_window_gen.sv
// Self-checking bench for sad_window_gen: directed streaming, stall, random handshake and reset scenarios
// scored against a frame-level reference model of every in-image window.
module tb_sad_window_gen;

    localparam int WIN   = 3;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int WW    = WIN * WIN * PIX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_pixel;
    logic             m_valid;
    logic             m_ready;
    logic [WW-1:0]    m_window;
    logic             m_last;
`ifdef SAD_WINGEN_COORD_EN
    logic [$clog2(IMG_W)-1:0] m_col;
    logic [$clog2(IMG_H)-1:0] m_row;
`endif

    sad_window_gen #(
        .WIN   (WIN),
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_pixel  (s_pixel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .m_last   (m_last)
`ifdef SAD_WINGEN_COORD_EN
        ,
        .m_col    (m_col),
        .m_row    (m_row)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] win;
        logic          last;
        int            ccol;
        int            crow;
    } exp_t;

    exp_t             exp_q[$];
    logic [PIX_W-1:0] src_q[$];

    int total = 0;
    int bad   = 0;
    int n_win, n_last, acc_cnt, first_acc;
    logic [WW-1:0] first_win, last_win;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every window is cut straight out of the stored frame.
    task automatic load_frame(input bit rnd);
        logic [PIX_W-1:0] img [IMG_H][IMG_W];
        exp_t e;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                img[r][c] = rnd ? PIX_W'($urandom) : PIX_W'(r * IMG_W + c);
                src_q.push_back(img[r][c]);
            end
        end
        for (int r = WIN - 1; r < IMG_H; r++) begin
            for (int c = WIN - 1; c < IMG_W; c++) begin
                e.win = '0;
                for (int i = 0; i < WIN; i++) begin
                    for (int j = 0; j < WIN; j++) begin
                        e.win[(i*WIN+j)*PIX_W +: PIX_W] = img[r-(WIN-1)+i][c-(WIN-1)+j];
                    end
                end
                e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
                e.ccol = c - (WIN - 1) / 2;
                e.crow = r - (WIN - 1) / 2;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run(input bit rnd_hs, input bit stall_first, input int budget);
        int            cyc = 0;
        int            stall_left = 0;
        bit            stall_started = 1'b0;
        logic [WW-1:0] held = '0;
        exp_t          e;
        n_win = 0; n_last = 0; acc_cnt = 0; first_acc = -1;
        first_win = '0; last_win = '0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (stall_first && !stall_started && m_valid) begin
                stall_started = 1'b1;
                stall_left    = 5;
            end
            s_valid = (src_q.size() > 0) && (rnd_hs ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_pixel = (src_q.size() > 0) ? src_q[0] : '0;
            if (stall_left > 0) m_ready = 1'b0;
            else                m_ready = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall_left > 0) begin
                check("stall_s_ready", s_ready, 0);
                if (stall_left < 5) check("stall_hold", m_window, held);
                held = m_window;
                stall_left--;
            end
            if (m_valid && first_acc < 0) first_acc = acc_cnt;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("window", m_window, e.win);
                    check("last", m_last, e.last);
`ifdef SAD_WINGEN_COORD_EN
                    check("m_col", m_col, e.ccol);
                    check("m_row", m_row, e.crow);
`endif
                end
                if (n_win == 0) first_win = m_window;
                if (m_last) begin
                    n_last++;
                    last_win = m_window;
                end
                n_win++;
            end
            if (s_valid && s_ready) begin
                void'(src_q.pop_front());
                acc_cnt++;
            end
            cyc++;
        end
        check("timeout_left", src_q.size() + exp_q.size(), 0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        logic [WW-1:0] want_first;
        logic [WW-1:0] want_last;
        want_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        want_last  = {8'd31, 8'd30, 8'd29, 8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13};

        rst_n = 1'b0; s_valid = 1'b0; s_pixel = '0; m_ready = 1'b0;
        #12;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_window", m_window, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous streaming
        load_frame(1'b0);
        run(1'b0, 1'b0, 500);
        check("s1_first_acc", first_acc, 19);
        check("s1_first_win", first_win, want_first);
        check("s1_last_win", last_win, want_last);
        check("s1_n_win", n_win, 12);
        check("s1_n_last", n_last, 1);

        // Backpressure on the first window
        load_frame(1'b0);
        run(1'b0, 1'b1, 500);
        check("s2_first_acc", first_acc, 19);
        check("s2_first_win", first_win, want_first);
        check("s2_last_win", last_win, want_last);
        check("s2_n_win", n_win, 12);

        // Random handshakes, random pixels, three back-to-back frames
        for (int f = 0; f < 3; f++) load_frame(1'b1);
        run(1'b1, 1'b0, 3000);
        check("s3_n_win", n_win, 36);
        check("s3_n_last", n_last, 3);

        // Reset in the middle of a frame
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_pixel = PIX_W'(i);
            m_ready = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_m_window", m_window, 0);
        @(negedge clk);
        rst_n = 1'b1;
        src_q.delete();
        exp_q.delete();
        load_frame(1'b0);
        run(1'b0, 1'b0, 500);
        check("s4_first_acc", first_acc, 19);
        check("s4_first_win", first_win, want_first);
        check("s4_last_win", last_win, want_last);
        check("s4_n_win", n_win, 12);
        check("s4_n_last", n_last, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
